// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready pipelined ALU with Z/N/C/V flags.
// S1 captures the operation; S2 computes and holds the result.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid / in_ready  input handshake
//   in_a, in_b           operands (DSIZE)
//   in_op                0 ADD 1 SUB 2 AND 3 XOR 4 SLL 5 SRL 6 SRA 7 ROR
//   in_imm               shift/rotate amount (IMMW)
//   in_sat               signed saturation for ADD/SUB
//   in_tag               sideband tag (TAGW)
//   out_valid/out_ready  output handshake
//   out_data             result (DSIZE)
//   out_flags            {Z,N,C,V}
//   out_tag              tag of the returned operation
module alu_pipe #(
  parameter int DSIZE = 16,
  parameter int IMMW  = 4,
  parameter int TAGW  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DSIZE-1:0] in_a,
  input  logic [DSIZE-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic [IMMW-1:0]  in_imm,
  input  logic             in_sat,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] out_data,
  output logic [3:0]       out_flags,
  output logic [TAGW-1:0]  out_tag
);

  localparam int MSB = DSIZE - 1;

  typedef struct packed {
    logic [DSIZE-1:0] a;
    logic [DSIZE-1:0] b;
    logic [2:0]       op;
    logic [IMMW-1:0]  imm;
    logic             sat;
    logic [TAGW-1:0]  tag;
  } s1_t;

  s1_t  s1_q;
  logic s1_valid;
  logic s2_free;
  logic s1_move;
  logic in_xfer;

  assign s2_free  = !out_valid || out_ready;
  assign s1_move  = s1_valid && s2_free;
  assign in_ready = !s1_valid || s1_move;
  assign in_xfer  = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= '0;
      s1_valid <= 1'b0;
    end else if (in_xfer) begin
      s1_q <= '{a:   in_a,
                b:   in_b,
                op:  in_op,
                imm: in_imm,
                sat: in_sat,
                tag: in_tag};
      s1_valid <= 1'b1;
    end else if (s1_move) begin
      s1_valid <= 1'b0;
    end
  end

  logic [DSIZE-1:0] a;
  logic [DSIZE-1:0] b;
  logic             is_add;
  logic             is_sub;
  logic             is_and;
  logic             is_xor;
  logic             is_sll;
  logic             is_srl;
  logic             is_sra;
  logic             is_ror;

  assign a      = s1_q.a;
  assign b      = s1_q.b;
  assign is_add = s1_q.op == 3'd0;
  assign is_sub = s1_q.op == 3'd1;
  assign is_and = s1_q.op == 3'd2;
  assign is_xor = s1_q.op == 3'd3;
  assign is_sll = s1_q.op == 3'd4;
  assign is_srl = s1_q.op == 3'd5;
  assign is_sra = s1_q.op == 3'd6;
  assign is_ror = s1_q.op == 3'd7;

  // Shared adder: SUB is a + ~b + 1.
  logic [DSIZE-1:0] bx;
  logic [DSIZE:0]   sum;
  logic             ovf;
  logic [DSIZE-1:0] sat_val;

  assign bx  = is_sub ? ~b : b;
  assign sum = {1'b0, a} + {1'b0, bx}
             + {{DSIZE{1'b0}}, is_sub};
  assign ovf = (a[MSB] == bx[MSB])
            && (sum[MSB] != a[MSB]);
  // Overflow direction follows the sign of a.
  assign sat_val = a[MSB]
    ? {1'b1, {(DSIZE-1){1'b0}}}
    : {1'b0, {(DSIZE-1){1'b1}}};

  // One extra bit beside the data catches the
  // last bit shifted out, including imm==DSIZE.
  logic [31:0]             amt;
  logic [31:0]             rk;
  logic [DSIZE:0]          sll_w;
  logic [DSIZE:0]          srl_w;
  logic signed [DSIZE:0]   sra_in;
  logic [DSIZE:0]          sra_w;
  logic [DSIZE-1:0]        ror_w;

  assign amt    = 32'(s1_q.imm);
  assign rk     = amt % 32'(DSIZE);
  assign sll_w  = {1'b0, a} << amt;
  assign srl_w  = {a, 1'b0} >> amt;
  assign sra_in = {a, 1'b0};
  assign sra_w  = sra_in >>> amt;
  assign ror_w  = (a >> rk)
                | (a << (32'(DSIZE) - rk));

  logic [DSIZE-1:0] res;
  logic             c;
  logic             v;

  always_comb begin
    res = '0;
    c   = 1'b0;
    v   = 1'b0;
    unique case (1'b1)
      is_add, is_sub: begin
        res = sum[MSB:0];
        c   = sum[DSIZE];
        v   = ovf;
        if (s1_q.sat && ovf) res = sat_val;
      end
      is_and: res = a & b;
      is_xor: res = a ^ b;
      is_sll: {c, res} = sll_w;
      is_srl: {res, c} = srl_w;
      is_sra: {res, c} = sra_w;
      is_ror: begin
        res = ror_w;
        c   = (rk != 32'd0) && ror_w[MSB];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_flags <= '0;
      out_tag   <= '0;
    end else if (s1_move) begin
      out_valid <= 1'b1;
      out_data  <= res;
      out_flags <= {res == '0, res[MSB], c, v};
      out_tag   <= s1_q.tag;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vector table plus backpressure,
// full-pipe and mid-stream reset sequences for alu_pipe.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [2:0]  in_op;
  logic [3:0]  in_imm;
  logic        in_sat;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_flags;
  logic [3:0]  out_tag;

  alu_pipe #(.DSIZE(16), .IMMW(4), .TAGW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_imm    (in_imm),
    .in_sat    (in_sat),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_flags (out_flags),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h",
               nm, act, req);
    end
  endtask

  typedef struct {
    logic [15:0] d;
    logic [3:0]  f;
    logic [3:0]  t;
    int          at;
  } exp_t;

  exp_t q[$];

  // Output scoreboard; at<0 means arrival cycle unchecked.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: tag %0h data %0h",
                 out_tag, out_data);
      end else begin
        e = q.pop_front();
        chk("data", 32'(out_data), 32'(e.d));
        chk("flags", 32'(out_flags), 32'(e.f));
        chk("tag", 32'(out_tag), 32'(e.t));
        if (e.at >= 0) chk("latency", cyc, e.at);
      end
    end
  end

  task automatic drive(input logic [2:0]  op,
                       input logic [15:0] a,
                       input logic [15:0] b,
                       input logic [3:0]  imm,
                       input logic        sat,
                       input logic [3:0]  tag);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_imm   = imm;
    in_sat   = sat;
    in_tag   = tag;
  endtask

  // Present an op, wait for acceptance, queue its result.
  task automatic send(input logic [2:0]  op,
                      input logic [15:0] a,
                      input logic [15:0] b,
                      input logic [3:0]  imm,
                      input logic        sat,
                      input logic [3:0]  tag,
                      input logic [15:0] d,
                      input logic [3:0]  f,
                      input bit          timed);
    int n;
    drive(op, a, b, imm, sat, tag);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      q.push_back('{d: d, f: f, t: tag,
                    at: timed ? cyc + 1 : -1});
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    chk("drain_left", 32'(q.size()), 32'd0);
    #1;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  imm;
    logic        sat;
    logic [15:0] r;
    logic [3:0]  f;
  } vec_t;

  vec_t vt[18];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = '0;
    in_imm    = '0;
    in_sat    = 1'b0;
    in_tag    = '0;
    out_ready = 1'b1;

    //        op    a         b         imm  sat  r         {Z,N,C,V}
    vt[0]  = '{3'd0, 16'h0001, 16'd12,   4'd0, 1'b0, 16'h000D, 4'b0000};
    vt[1]  = '{3'd1, 16'd21,   16'd12,   4'd0, 1'b0, 16'h0009, 4'b0010};
    vt[2]  = '{3'd2, 16'h002E, 16'h0016, 4'd0, 1'b0, 16'h0006, 4'b0000};
    vt[3]  = '{3'd3, 16'h0034, 16'h0026, 4'd0, 1'b0, 16'h0012, 4'b0000};
    vt[4]  = '{3'd0, 16'h7FFF, 16'h0001, 4'd0, 1'b0, 16'h8000, 4'b0101};
    vt[5]  = '{3'd0, 16'h7FFF, 16'h0001, 4'd0, 1'b1, 16'h7FFF, 4'b0001};
    vt[6]  = '{3'd1, 16'h8000, 16'h0001, 4'd0, 1'b1, 16'h8000, 4'b0111};
    vt[7]  = '{3'd4, 16'h000A, 16'h0000, 4'd4, 1'b0, 16'h00A0, 4'b0000};
    vt[8]  = '{3'd5, 16'h000B, 16'h0000, 4'd3, 1'b0, 16'h0001, 4'b0000};
    vt[9]  = '{3'd6, 16'h8000, 16'h0000, 4'd15, 1'b0, 16'hFFFF, 4'b0100};
    vt[10] = '{3'd7, 16'h000E, 16'h0000, 4'd4, 1'b0, 16'hE000, 4'b0110};
    vt[11] = '{3'd4, 16'hFFFF, 16'h0000, 4'd0, 1'b0, 16'hFFFF, 4'b0100};
    vt[12] = '{3'd2, 16'h00F0, 16'h0F00, 4'd0, 1'b0, 16'h0000, 4'b1000};
    vt[13] = '{3'd1, 16'h0005, 16'h0007, 4'd0, 1'b0, 16'hFFFE, 4'b0100};
    vt[14] = '{3'd5, 16'h4000, 16'h0000, 4'd15, 1'b0, 16'h0000, 4'b1010};
    vt[15] = '{3'd0, 16'hFFFF, 16'h0001, 4'd0, 1'b1, 16'h0000, 4'b1010};
    vt[16] = '{3'd7, 16'h8001, 16'h0000, 4'd0, 1'b0, 16'h8001, 4'b0100};
    vt[17] = '{3'd4, 16'h0003, 16'h0000, 4'd15, 1'b0, 16'h8000, 4'b0110};

    // Reset state
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_flags", 32'(out_flags), 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    #20;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Streaming table, back-to-back, latency checked
    for (int i = 0; i < 18; i++) begin
      send(vt[i].op, vt[i].a, vt[i].b, vt[i].imm,
           vt[i].sat, 4'(i), vt[i].r, vt[i].f, 1'b1);
    end
    in_valid = 1'b0;
    drain();

    // Backpressure with tags 1,2,3
    out_ready = 1'b0;
    send(3'd0, 16'h0100, 16'h0001, 4'd0, 1'b0,
         4'd1, 16'h0101, 4'b0000, 1'b0);
    send(3'd0, 16'h0200, 16'h0001, 4'd0, 1'b0,
         4'd2, 16'h0201, 4'b0000, 1'b0);
    drive(3'd0, 16'h0300, 16'h0001, 4'd0, 1'b0, 4'd3);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_data", 32'(out_data), 32'h0101);
      chk("bp_out_tag", 32'(out_tag), 32'd1);
    end

    // Full pipe: output, S1 move and input in one edge
    out_ready = 1'b1;
    #1;
    chk("full_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    q.push_back('{d: 16'h0301, f: 4'b0000, t: 4'd3,
                  at: cyc + 1});
    in_valid = 1'b0;
    chk("full_out_tag", 32'(out_tag), 32'd2);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    chk("full_in_ready_after", 32'(in_ready), 32'd1);
    drain();

    // Reset with two ops in flight
    send(3'd0, 16'h0010, 16'h0020, 4'd0, 1'b0,
         4'hA, 16'h0030, 4'b0000, 1'b1);
    send(3'd3, 16'h00FF, 16'h000F, 4'd0, 1'b0,
         4'hB, 16'h00F0, 4'b0000, 1'b1);
    in_valid = 1'b0;
    #1;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_tag", 32'(out_tag), 32'hA);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    q.delete();
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    send(3'd1, 16'h0100, 16'h0001, 4'd0, 1'b0,
         4'hC, 16'h00FF, 4'b0010, 1'b1);
    in_valid = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
